// File: rtl/controlador_memoria.sv
// Burst memory controller: accepts read/write bursts of 1..16 beats and drives a
// single-port data memory with registered strobes, address and write data.
module controlador_memoria (
    input  logic       clock,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic [7:0] req_addr,
    input  logic [3:0] req_len,
    input  logic [7:0] wr_data,
    input  logic       wr_valid,
    output logic       wr_ready,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       done,
    output logic [7:0] mem_endereco,
    output logic       mem_controle_escrita,
    output logic       mem_controle_leitura,
    output logic [7:0] mem_dado_entrada,
    input  logic [7:0] mem_dado_saida
);

    typedef enum logic [1:0] {Ocioso, Leitura, Escrita, Conclui} estado_t;

    estado_t    estado_q, estado_d;
    logic [3:0] cont_q, cont_d;
    logic [7:0] prox_end_q, prox_end_d;
    logic [7:0] endereco_q, endereco_d;
    logic [7:0] dado_ent_q, dado_ent_d;
    logic       escrita_q, escrita_d;
    logic       leitura_q, leitura_d;
    logic [7:0] rd_data_q, rd_data_d;
    logic       rd_valid_q, rd_valid_d;
    logic       done_q, done_d;

    always_comb begin
        estado_d   = estado_q;
        cont_d     = cont_q;
        prox_end_d = prox_end_q;
        endereco_d = endereco_q;
        dado_ent_d = dado_ent_q;
        rd_data_d  = rd_data_q;
        escrita_d  = 1'b0;
        leitura_d  = 1'b0;
        rd_valid_d = 1'b0;
        done_d     = 1'b0;

        unique case (estado_q)
            Ocioso: begin
                if (req_valid) begin
                    cont_d     = req_len;
                    endereco_d = req_addr;
                    prox_end_d = req_addr;
                    if (req_write) begin
                        estado_d = Escrita;
                    end else begin
                        estado_d  = Leitura;
                        leitura_d = 1'b1;
                    end
                end
            end
            Leitura: begin
                // Data for the strobe cycle now ending is stable at this edge.
                rd_valid_d = 1'b1;
                rd_data_d  = mem_dado_saida;
                if (cont_q == 4'd0) begin
                    estado_d = Conclui;
                    done_d   = 1'b1;
                end else begin
                    cont_d     = cont_q - 4'd1;
                    endereco_d = endereco_q + 8'd1;
                    leitura_d  = 1'b1;
                end
            end
            Escrita: begin
                // prox_end_q tracks the next beat address; mem_endereco only moves on a beat.
                if (wr_valid) begin
                    escrita_d  = 1'b1;
                    dado_ent_d = wr_data;
                    endereco_d = prox_end_q;
                    prox_end_d = prox_end_q + 8'd1;
                    if (cont_q == 4'd0) begin
                        estado_d = Conclui;
                        done_d   = 1'b1;
                    end else begin
                        cont_d = cont_q - 4'd1;
                    end
                end
            end
            Conclui: begin
                estado_d = Ocioso;
            end
            default: begin
                estado_d = Ocioso;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q   <= Ocioso;
            cont_q     <= 4'd0;
            prox_end_q <= 8'd0;
            endereco_q <= 8'd0;
            dado_ent_q <= 8'd0;
            escrita_q  <= 1'b0;
            leitura_q  <= 1'b0;
            rd_data_q  <= 8'd0;
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            estado_q   <= estado_d;
            cont_q     <= cont_d;
            prox_end_q <= prox_end_d;
            endereco_q <= endereco_d;
            dado_ent_q <= dado_ent_d;
            escrita_q  <= escrita_d;
            leitura_q  <= leitura_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            done_q     <= done_d;
        end
    end

    assign req_ready            = (estado_q == Ocioso);
    assign wr_ready             = (estado_q == Escrita);
    assign rd_data              = rd_data_q;
    assign rd_valid             = rd_valid_q;
    assign done                 = done_q;
    assign mem_endereco         = endereco_q;
    assign mem_controle_escrita = escrita_q;
    assign mem_controle_leitura = leitura_q;
    assign mem_dado_entrada     = dado_ent_q;

endmodule

// File: tb/tb_controlador_memoria.sv
// Directed bench for controlador_memoria with a behavioural data memory
// (write committed at rising edge, read latched at falling edge).
module tb_controlador_memoria;

    logic       clock = 1'b0;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic       req_write;
    logic [7:0] req_addr;
    logic [3:0] req_len;
    logic [7:0] wr_data;
    logic       wr_valid;
    logic       wr_ready;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       done;
    logic [7:0] mem_endereco;
    logic       mem_controle_escrita;
    logic       mem_controle_leitura;
    logic [7:0] mem_dado_entrada;
    logic [7:0] mem_dado_saida;

    int checks = 0;
    int errors = 0;
    int strobes = 0;
    bit mon_en = 1'b0;

    logic [7:0] mem        [256];
    logic [7:0] expect_mem [256];
    logic [7:0] wdata      [16];

    controlador_memoria dut (
        .clock               (clock),
        .reset               (reset),
        .req_valid           (req_valid),
        .req_ready           (req_ready),
        .req_write           (req_write),
        .req_addr            (req_addr),
        .req_len             (req_len),
        .wr_data             (wr_data),
        .wr_valid            (wr_valid),
        .wr_ready            (wr_ready),
        .rd_data             (rd_data),
        .rd_valid            (rd_valid),
        .done                (done),
        .mem_endereco        (mem_endereco),
        .mem_controle_escrita(mem_controle_escrita),
        .mem_controle_leitura(mem_controle_leitura),
        .mem_dado_entrada    (mem_dado_entrada),
        .mem_dado_saida      (mem_dado_saida)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (mem_controle_escrita) mem[mem_endereco] <= mem_dado_entrada;
        if (mem_controle_escrita) strobes++;
    end

    always @(negedge clock) begin
        if (mem_controle_leitura) mem_dado_saida <= mem[mem_endereco];
    end

    always @(negedge clock) begin
        if (mon_en) begin
            checks++;
            if (mem_controle_escrita && mem_controle_leitura) begin
                errors++;
                $display("FAIL strobe_exclusive got escrita=%b leitura=%b need not both 1",
                         mem_controle_escrita, mem_controle_leitura);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout need finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = 8'h00; req_len = 4'h0;
        wr_data = 8'h00; wr_valid = 1'b0;
        tick();
        tick();
        checks++;
        if ({req_ready, wr_ready, rd_valid, done, mem_controle_escrita, mem_controle_leitura}
            !== 6'b100000) begin
            errors++;
            $display("FAIL reset_ctrl got %b need 100000", {req_ready, wr_ready, rd_valid, done,
                     mem_controle_escrita, mem_controle_leitura});
        end
        checks++;
        if ({mem_endereco, mem_dado_entrada, rd_data} !== 24'h0) begin
            errors++;
            $display("FAIL reset_data got %h need 000000", {mem_endereco, mem_dado_entrada, rd_data});
        end
        reset = 1'b0;
        wr_valid = 1'b1;
        wr_data = 8'hEE;
        tick();
        checks++;
        if ({mem_controle_escrita, wr_ready, req_ready} !== 3'b001) begin
            errors++;
            $display("FAIL idle_wr_ignored got %b need 001",
                     {mem_controle_escrita, wr_ready, req_ready});
        end
        wr_valid = 1'b0;
    endtask

    task automatic test_write_burst(input logic [7:0] a, input logic [3:0] l, input int stall);
        logic [7:0] ea;
        req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_len = l;
        tick();
        req_valid = 1'b0;
        checks++;
        if ({wr_ready, req_ready, mem_controle_escrita} !== 3'b100) begin
            errors++;
            $display("FAIL wr_start got %b need 100", {wr_ready, req_ready, mem_controle_escrita});
        end
        wr_valid = 1'b1;
        wr_data = wdata[0];
        for (int i = 0; i <= int'(l); i++) begin
            ea = a + 8'(i);
            expect_mem[ea] = wdata[i];
            tick();
            checks++;
            if ({mem_controle_escrita, mem_endereco, mem_dado_entrada, done}
                !== {1'b1, ea, wdata[i], i == int'(l)}) begin
                errors++;
                $display("FAIL wr_beat%0d got st=%b ad=%h d=%h dn=%b need st=1 ad=%h d=%h dn=%b",
                         i, mem_controle_escrita, mem_endereco, mem_dado_entrada, done,
                         ea, wdata[i], i == int'(l));
            end
            if (i < int'(l)) begin
                if (i == 0 && stall > 0) begin
                    wr_valid = 1'b0;
                    for (int s = 0; s < stall; s++) begin
                        tick();
                        checks++;
                        if ({mem_controle_escrita, mem_endereco, wr_ready, done}
                            !== {1'b0, a, 1'b1, 1'b0}) begin
                            errors++;
                            $display("FAIL wr_stall%0d got st=%b ad=%h rdy=%b dn=%b need 0 %h 1 0",
                                     s, mem_controle_escrita, mem_endereco, wr_ready, done, a);
                        end
                    end
                    wr_valid = 1'b1;
                end
                wr_data = wdata[i+1];
            end else begin
                wr_valid = 1'b0;
            end
        end
        tick();
        checks++;
        if ({mem_controle_escrita, done, req_ready, wr_ready, mem_endereco}
            !== {4'b0010, a + 8'(l)}) begin
            errors++;
            $display("FAIL wr_end got st=%b dn=%b rr=%b wr=%b ad=%h need 0 0 1 0 %h",
                     mem_controle_escrita, done, req_ready, wr_ready, mem_endereco, a + 8'(l));
        end
        for (int i = 0; i <= int'(l); i++) begin
            ea = a + 8'(i);
            checks++;
            if (mem[ea] !== wdata[i]) begin
                errors++;
                $display("FAIL wr_mem[%h] got %h need %h", ea, mem[ea], wdata[i]);
            end
        end
    endtask

    task automatic test_read_burst(input logic [7:0] a, input logic [3:0] l);
        logic [7:0] ea;
        logic [7:0] ed;
        logic       last;
        req_valid = 1'b1; req_write = 1'b0; req_addr = a; req_len = l;
        tick();
        req_valid = 1'b0;
        checks++;
        if ({mem_controle_leitura, mem_endereco, rd_valid, done, req_ready}
            !== {1'b1, a, 3'b000}) begin
            errors++;
            $display("FAIL rd_start got le=%b ad=%h rv=%b dn=%b rr=%b need 1 %h 0 0 0",
                     mem_controle_leitura, mem_endereco, rd_valid, done, req_ready, a);
        end
        for (int c = 2; c <= int'(l) + 2; c++) begin
            tick();
            ea = a + 8'(c - 1);
            ed = expect_mem[a + 8'(c - 2)];
            last = (c == int'(l) + 2);
            checks++;
            if ({mem_controle_leitura, rd_valid, rd_data, done} !== {!last, 1'b1, ed, last}) begin
                errors++;
                $display("FAIL rd_cycle%0d got le=%b rv=%b d=%h dn=%b need %b 1 %h %b",
                         c, mem_controle_leitura, rd_valid, rd_data, done, !last, ed, last);
            end
            if (!last) begin
                checks++;
                if (mem_endereco !== ea) begin
                    errors++;
                    $display("FAIL rd_addr%0d got %h need %h", c, mem_endereco, ea);
                end
            end
        end
        tick();
        checks++;
        if ({mem_controle_leitura, rd_valid, done, req_ready} !== 4'b0001) begin
            errors++;
            $display("FAIL rd_end got %b need 0001",
                     {mem_controle_leitura, rd_valid, done, req_ready});
        end
    endtask

    task automatic test_back_to_back();
        req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h11; req_len = 4'h0;
        tick();
        req_addr = 8'h12;
        checks++;
        if ({mem_controle_leitura, mem_endereco, req_ready} !== {1'b1, 8'h11, 1'b0}) begin
            errors++;
            $display("FAIL b2b_first got le=%b ad=%h rr=%b need 1 11 0",
                     mem_controle_leitura, mem_endereco, req_ready);
        end
        tick();
        checks++;
        if ({done, rd_valid, rd_data, req_ready} !== {2'b11, 8'hA1, 1'b0}) begin
            errors++;
            $display("FAIL b2b_done1 got dn=%b rv=%b d=%h rr=%b need 1 1 a1 0",
                     done, rd_valid, rd_data, req_ready);
        end
        tick();
        checks++;
        if ({req_ready, done, rd_valid, mem_controle_leitura} !== 4'b1000) begin
            errors++;
            $display("FAIL b2b_idle got %b need 1000",
                     {req_ready, done, rd_valid, mem_controle_leitura});
        end
        tick();
        req_valid = 1'b0;
        checks++;
        if ({mem_controle_leitura, mem_endereco, req_ready} !== {1'b1, 8'h12, 1'b0}) begin
            errors++;
            $display("FAIL b2b_second got le=%b ad=%h rr=%b need 1 12 0",
                     mem_controle_leitura, mem_endereco, req_ready);
        end
        tick();
        checks++;
        if ({done, rd_valid, rd_data} !== {2'b11, 8'hA2}) begin
            errors++;
            $display("FAIL b2b_done2 got dn=%b rv=%b d=%h need 1 1 a2", done, rd_valid, rd_data);
        end
        tick();
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_end got rr=%b need 1", req_ready);
        end
    endtask

    task automatic test_reset_mid_read();
        req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h20; req_len = 4'h7;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        checks++;
        if ({rd_valid, mem_controle_leitura, done} !== 3'b110) begin
            errors++;
            $display("FAIL rst_mid_pre got %b need 110", {rd_valid, mem_controle_leitura, done});
        end
        reset = 1'b1;
        tick();
        checks++;
        if ({rd_valid, mem_controle_leitura, done, req_ready, mem_endereco}
            !== {4'b0001, 8'h00}) begin
            errors++;
            $display("FAIL rst_mid_abort got rv=%b le=%b dn=%b rr=%b ad=%h need 0 0 0 1 00",
                     rd_valid, mem_controle_leitura, done, req_ready, mem_endereco);
        end
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            checks++;
            if ({rd_valid, mem_controle_leitura, done, req_ready} !== 4'b0001) begin
                errors++;
                $display("FAIL rst_mid_after%0d got %b need 0001", k,
                         {rd_valid, mem_controle_leitura, done, req_ready});
            end
        end
    endtask

    initial begin
        test_reset();
        mon_en = 1'b1;

        for (int i = 0; i < 4; i++) wdata[i] = 8'hA0 + 8'(i);
        test_write_burst(8'h10, 4'd3, 0);
        test_read_burst(8'h10, 4'd3);
        test_back_to_back();

        wdata[0] = 8'h11; wdata[1] = 8'h22; wdata[2] = 8'h33;
        test_write_burst(8'hFE, 4'd2, 0);
        test_read_burst(8'hFE, 4'd2);

        wdata[0] = 8'h5A; wdata[1] = 8'h5B;
        strobes = 0;
        test_write_burst(8'h40, 4'd1, 2);
        checks++;
        if (strobes != 2) begin
            errors++;
            $display("FAIL stall_strobes got %0d need 2", strobes);
        end

        wdata[0] = 8'hC3;
        test_write_burst(8'h55, 4'd0, 0);
        test_read_burst(8'h55, 4'd0);

        test_reset_mid_read();

        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
